// File: rtl/adventure_pkg.sv
// Shared types and defaults for the adventure-game room controller.
package adventure_pkg;

  typedef enum logic [2:0] {
    CAVE      = 3'd0,
    TUNNEL    = 3'd1,
    RIVER     = 3'd2,
    STASH     = 3'd3,
    DEN       = 3'd4,
    GRAVEYARD = 3'd5,
    VAULT     = 3'd6
  } room_t;

  localparam int MAX_MOVES_DEFAULT = 31;

  function automatic logic isTerminal(input room_t r);
    return (r == GRAVEYARD) || (r == VAULT);
  endfunction

endpackage

// File: rtl/sword_latch.sv
// Set-only flag: once sw is seen high on a rising edge, v stays high until R_n.
module sword_latch (
  input  logic clock,
  input  logic R_n,
  input  logic sw,
  output logic v
);

  logic v_q;

  always_ff @(posedge clock or negedge R_n) begin
    if (!R_n) v_q <= 1'b0;
    else if (sw) v_q <= 1'b1;
  end

  assign v = v_q;

endmodule

// File: rtl/adventure_ctrl.sv
// Top-level game FSM: room register, exits, dragon resolution and move counter.
// Optional move budget enforcement is built when ADV_MOVE_LIMIT_EN is defined.
module adventure_ctrl
  import adventure_pkg::*;
#(
  parameter int MAX_MOVES = MAX_MOVES_DEFAULT,
  parameter int CNT_W     = $clog2(MAX_MOVES + 1)
) (
  input  logic             clock,
  input  logic             R_n,
  input  logic             N,
  input  logic             S,
  input  logic             E,
  input  logic             W,
  output logic [2:0]       room,
  output logic             sword,
  output logic             win,
  output logic             lose,
  output logic [CNT_W-1:0] moves
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_MOVES);

  room_t            room_q, room_d, target;
  logic [CNT_W-1:0] moves_q, moves_d;
  logic             dirValid, moveOk, atLimit, swStrobe, swordHeld;

  always_ff @(posedge clock or negedge R_n) begin
    if (!R_n) begin
      room_q  <= CAVE;
      moves_q <= '0;
    end else begin
      room_q  <= room_d;
      moves_q <= moves_d;
    end
  end

  always_comb begin
    target   = room_q;
    dirValid = $onehot({N, S, E, W});
    atLimit  = (moves_q == MaxCnt);
    if (dirValid) begin
      unique case (room_q)
        CAVE:    if (E) target = TUNNEL;
        TUNNEL:  if (W) target = CAVE; else if (S) target = RIVER;
        RIVER:   if (N) target = TUNNEL; else if (W) target = STASH; else if (E) target = DEN;
        STASH:   if (E) target = RIVER;
        default: target = room_q;
      endcase
    end
    // DEN and terminal rooms never produce a different target, so moveOk stays low there
    moveOk  = dirValid && (target != room_q);
    room_d  = room_q;
    moves_d = moves_q;
    if (room_q == DEN) begin
      room_d = swordHeld ? VAULT : GRAVEYARD;
    end else if (moveOk) begin
`ifdef ADV_MOVE_LIMIT_EN
      room_d = atLimit ? GRAVEYARD : target;
`else
      room_d = target;
`endif
      if (!atLimit) moves_d = moves_q + CNT_W'(1);
    end
  end

  always_comb begin
    swStrobe = (room_q == STASH);
    win      = (room_q == VAULT);
    lose     = (room_q == GRAVEYARD) && isTerminal(room_q);
  end

  sword_latch uSwordLatch (
    .clock (clock),
    .R_n   (R_n),
    .sw    (swStrobe),
    .v     (swordHeld)
  );

  assign room  = room_q;
  assign sword = swordHeld;
  assign moves = moves_q;

endmodule
